// File: rtl/servo_pkg.sv
// servo_pkg: shared types, default timing constants and the width clamp helper
// for the servo PWM driver.
//   pw_t            17-bit pulse width in clocks
//   frame_state_t   frame sequencer states
//   clamp_width()   saturates an 18-bit signed width into [lo, hi]
package servo_pkg;

  localparam int PW_W = 17;
  typedef logic [PW_W-1:0] pw_t;

  localparam int DEF_FRAME_CYCLES = 1_000_000;
  localparam int DEF_PULSE_CENTER = 75_000;
  localparam int DEF_PULSE_MIN    = 50_000;
  localparam int DEF_PULSE_MAX    = 100_000;
  localparam int DEF_GAIN_SHIFT   = 2;
  localparam int DEF_STALE_FRAMES = 8;
  localparam int DEF_SLEW_STEP    = 500;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } frame_state_t;

  function automatic pw_t clamp_width(input logic signed [17:0] v,
                                      input pw_t lo, input pw_t hi);
    logic signed [17:0] lo_s;
    logic signed [17:0] hi_s;
    lo_s = signed'({1'b0, lo});
    hi_s = signed'({1'b0, hi});
    if (v < lo_s)      return lo;
    else if (v > hi_s) return hi;
    else               return pw_t'(v);
  endfunction

endpackage

// File: rtl/servo_channel.sv
// servo_channel: one servo output. Holds the shadow angle, derives the
// clamped proportional target, updates the active width at the frame update
// point and produces the registered PWM compare.
// Build option: SLEW_LIMIT_EN limits each width update to SLEW_STEP clocks.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   angle         signed angle input
//   angle_valid   load strobe for the shadow angle
//   upd           frame update point (last cycle of the frame)
//   neutral       force PULSE_CENTER as target
//   cnt_nxt       frame counter value for the next cycle
//   servo         PWM output, high while counter < width
//   width         active pulse width in clocks
module servo_channel
  import servo_pkg::*;
#(
  parameter int CNT_W        = 20,
  parameter int PULSE_CENTER = DEF_PULSE_CENTER,
  parameter int PULSE_MIN    = DEF_PULSE_MIN,
  parameter int PULSE_MAX    = DEF_PULSE_MAX,
  parameter int GAIN_SHIFT   = DEF_GAIN_SHIFT,
  parameter int SLEW_STEP    = DEF_SLEW_STEP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] angle,
  input  logic               angle_valid,
  input  logic               upd,
  input  logic               neutral,
  input  logic [CNT_W-1:0]   cnt_nxt,
  output logic               servo,
  output pw_t                width
);

  logic signed [15:0] shadow;
  logic signed [15:0] corr16;
  logic signed [17:0] corr;
  logic signed [17:0] raw;
  pw_t                target;
  pw_t                width_nxt;

  always_comb begin
    corr16 = shadow >>> GAIN_SHIFT;
    corr   = {{2{corr16[15]}}, corr16};
    raw    = signed'(18'(PULSE_CENTER)) - corr;
    target = neutral ? pw_t'(PULSE_CENTER)
                     : clamp_width(raw, pw_t'(PULSE_MIN), pw_t'(PULSE_MAX));
  end

`ifdef SLEW_LIMIT_EN
  localparam pw_t STEP = pw_t'(SLEW_STEP);

  always_comb begin
    width_nxt = width;
    if (upd) begin
      if (target > width)
        width_nxt = ((target - width) > STEP) ? width + STEP : target;
      else
        width_nxt = ((width - target) > STEP) ? width - STEP : target;
    end
  end
`else
  always_comb begin
    width_nxt = width;
    if (upd) width_nxt = target;
  end
`endif

  // Compare against next-cycle counter and width so servo lines up with cnt
  // and a new width takes effect exactly at cnt == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      width  <= pw_t'(PULSE_CENTER);
      servo  <= 1'b0;
    end else begin
      if (angle_valid) shadow <= angle;
      width <= width_nxt;
      servo <= (32'(cnt_nxt) < 32'(width_nxt));
    end
  end

endmodule

// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver: two 50 Hz hobby-servo pulse trains (elevator from pitch,
// aileron from roll) with a proportional correction law, frame-aligned width
// updates and a neutral fallback when angles go stale or enable is low.
// Build option: SLEW_LIMIT_EN (rate-limits width changes per frame).
// Ports:
//   MAX10_CLK1_50          system clock
//   rst_n                  async active-low reset
//   pitch, roll            signed angles, sampled on angle_valid
//   angle_valid            1-cycle angle strobe
//   enable                 0 forces neutral on both channels
//   servo_elev, servo_ail  PWM outputs
//   frame_start            high while the frame counter is 0
//   width_elev, width_ail  active widths in clocks
//
// state    | meaning
// ST_LOAD  | last cycle of the frame; widths take their targets
// ST_PULSE | counter below the wider of the two active widths
// ST_GAP   | both pulses finished, waiting for the frame end
module servo_pwm_driver
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int PULSE_CENTER = DEF_PULSE_CENTER,
  parameter int PULSE_MIN    = DEF_PULSE_MIN,
  parameter int PULSE_MAX    = DEF_PULSE_MAX,
  parameter int GAIN_SHIFT   = DEF_GAIN_SHIFT,
  parameter int STALE_FRAMES = DEF_STALE_FRAMES,
  parameter int SLEW_STEP    = DEF_SLEW_STEP
) (
  input  logic               MAX10_CLK1_50,
  input  logic               rst_n,
  input  logic signed [15:0] pitch,
  input  logic signed [15:0] roll,
  input  logic               angle_valid,
  input  logic               enable,
  output logic               servo_elev,
  output logic               servo_ail,
  output logic               frame_start,
  output logic [16:0]        width_elev,
  output logic [16:0]        width_ail
);

  localparam int CNT_W   = $clog2(FRAME_CYCLES);
  localparam int STALE_W = (STALE_FRAMES < 2) ? 1 : $clog2(STALE_FRAMES + 1);
  localparam logic [CNT_W-1:0]   LAST      = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0]   PRE_LAST  = CNT_W'(FRAME_CYCLES - 2);
  localparam logic [STALE_W-1:0] STALE_SAT = STALE_W'(STALE_FRAMES);

  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [STALE_W-1:0] stale;
  frame_state_t       state;
  frame_state_t       state_nxt;
  logic               upd;
  logic               neutral;
  pw_t                max_w;

  assign cnt_nxt = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
  assign max_w   = (width_elev > width_ail) ? width_elev : width_ail;
  assign neutral = !enable || ((STALE_FRAMES != 0) && (stale >= STALE_SAT));

  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      state       <= ST_PULSE;
      stale       <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      state       <= state_nxt;
      frame_start <= (cnt_nxt == '0);
      // A strobe always wins over the per-frame increment.
      if (angle_valid)
        stale <= '0;
      else if (upd && stale != STALE_SAT)
        stale <= stale + STALE_W'(1);
    end
  end

  // The sequencer re-locks to the counter: LOAD is entered only from the
  // cycle before the last, so an upset state recovers within one frame.
  always_comb begin
    state_nxt = state;
    upd       = 1'b0;
    case (state)
      ST_LOAD: begin
        upd       = 1'b1;
        state_nxt = ST_PULSE;
      end
      ST_PULSE: begin
        if (cnt == PRE_LAST)
          state_nxt = ST_LOAD;
        else if (32'(cnt_nxt) >= 32'(max_w))
          state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (cnt == PRE_LAST) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  servo_channel #(
    .CNT_W(CNT_W), .PULSE_CENTER(PULSE_CENTER), .PULSE_MIN(PULSE_MIN),
    .PULSE_MAX(PULSE_MAX), .GAIN_SHIFT(GAIN_SHIFT), .SLEW_STEP(SLEW_STEP)
  ) u_elev (
    .clk(MAX10_CLK1_50), .rst_n(rst_n), .angle(pitch), .angle_valid(angle_valid),
    .upd(upd), .neutral(neutral), .cnt_nxt(cnt_nxt),
    .servo(servo_elev), .width(width_elev)
  );

  servo_channel #(
    .CNT_W(CNT_W), .PULSE_CENTER(PULSE_CENTER), .PULSE_MIN(PULSE_MIN),
    .PULSE_MAX(PULSE_MAX), .GAIN_SHIFT(GAIN_SHIFT), .SLEW_STEP(SLEW_STEP)
  ) u_ail (
    .clk(MAX10_CLK1_50), .rst_n(rst_n), .angle(roll), .angle_valid(angle_valid),
    .upd(upd), .neutral(neutral), .cnt_nxt(cnt_nxt),
    .servo(servo_ail), .width(width_ail)
  );

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Bench for servo_pwm_driver with a shortened frame. A frame-level model
// pushes the expected widths after each frame's stimulus; a monitor measures
// every frame's pulse lengths and period and pops the expectation.
module tb_servo_pwm_driver;

  localparam int F     = 1000;
  localparam int C     = 300;
  localparam int PMIN  = 200;
  localparam int PMAX  = 400;
  localparam int G     = 2;
  localparam int STALE = 8;
  localparam int SLEW  = 20;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] pitch;
  logic signed [15:0] roll;
  logic               angle_valid;
  logic               enable;
  logic               servo_elev;
  logic               servo_ail;
  logic               frame_start;
  logic [16:0]        width_elev;
  logic [16:0]        width_ail;

  always #5 clk = ~clk;

  servo_pwm_driver #(
    .FRAME_CYCLES(F), .PULSE_CENTER(C), .PULSE_MIN(PMIN), .PULSE_MAX(PMAX),
    .GAIN_SHIFT(G), .STALE_FRAMES(STALE), .SLEW_STEP(SLEW)
  ) dut (
    .MAX10_CLK1_50(clk), .rst_n(rst_n), .pitch(pitch), .roll(roll),
    .angle_valid(angle_valid), .enable(enable),
    .servo_elev(servo_elev), .servo_ail(servo_ail), .frame_start(frame_start),
    .width_elev(width_elev), .width_ail(width_ail)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  typedef struct {int e; int a;} exp_t;
  typedef struct {bit en; int pos; int p; int r; int pos2; int p2; int r2;} step_t;

  exp_t  exp_q[$];
  step_t steps[$];

  int sh_p = 0, sh_r = 0, stale = 0, w_e = C, w_a = C;

  function automatic int tgt(input int ang, input bit neu);
    int v;
    if (neu) return C;
    v = C - (ang >>> G);
    if (v < PMIN) return PMIN;
    if (v > PMAX) return PMAX;
    return v;
  endfunction

  function automatic int step_w(input int w, input int t);
`ifdef SLEW_LIMIT_EN
    if (t > w) return (t - w > SLEW) ? w + SLEW : t;
    return (w - t > SLEW) ? w - SLEW : t;
`else
    return t;
`endif
  endfunction

  function automatic void model_update(input bit en);
    bit neu;
    neu = !en || (STALE != 0 && stale >= STALE);
    w_e = step_w(w_e, tgt(sh_p, neu));
    w_a = step_w(w_a, tgt(sh_r, neu));
    if (stale < STALE) stale++;
  endfunction

  function automatic void model_strobe(input int p, input int r);
    sh_p  = p;
    sh_r  = r;
    stale = 0;
  endfunction

  function automatic void add(input bit en, input int pos, input int p, input int r,
                              input int pos2, input int p2, input int r2);
    step_t s;
    s.en = en; s.pos = pos; s.p = p; s.r = r; s.pos2 = pos2; s.p2 = p2; s.r2 = r2;
    steps.push_back(s);
  endfunction

  task automatic strobe(input int p, input int r);
    pitch       = 16'(p);
    roll        = 16'(r);
    angle_valid = 1'b1;
    @(negedge clk);
    angle_valid = 1'b0;
  endtask

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  endtask

  // Starts on a negedge with cnt == 0; returns on the next frame's cnt == 0.
  task automatic run_step(input step_t s);
    int cur;
    int n;
    bit late;
    cur  = 0;
    late = 0;
    enable = s.en;
    if (s.pos >= 0) begin
      repeat (s.pos) @(negedge clk);
      strobe(s.p, s.r);
      cur = s.pos + 1;
      if (s.pos == F - 1) late = 1;
      else model_strobe(s.p, s.r);
    end
    if (s.pos2 >= 0) begin
      repeat (s.pos2 - cur) @(negedge clk);
      strobe(s.p2, s.r2);
      cur = s.pos2 + 1;
      model_strobe(s.p2, s.r2);
    end
    model_update(s.en);
    if (late) model_strobe(s.p, s.r);
    exp_q.push_back('{e: w_e, a: w_a});
    if (cur == 0) @(negedge clk);
    n = 0;
    while (!frame_start && n < 2 * F) begin
      @(negedge clk);
      n++;
    end
    if (!frame_start) begin
      n_err++;
      $display("FAIL stim_sync: no frame_start within %0d cycles", 2 * F);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $fatal(1, "lost frame sync");
    end
  endtask

  task automatic measure(input int nframes);
    for (int i = 0; i < nframes; i++) begin
      int he, ha, we, wa;
      exp_t x;
      he = 0; ha = 0;
      we = int'(width_elev);
      wa = int'(width_ail);
      for (int k = 0; k < F; k++) begin
        he += int'(servo_elev);
        ha += int'(servo_ail);
        if (k == F / 2) check($sformatf("f%0d_fs_mid", i), int'(frame_start), 0);
        @(negedge clk);
      end
      check($sformatf("f%0d_period", i), int'(frame_start), 1);
      if (exp_q.size() == 0) begin
        check($sformatf("f%0d_sb_empty", i), 0, 1);
      end else begin
        x = exp_q.pop_front();
        check($sformatf("f%0d_elev_high", i), he, x.e);
        check($sformatf("f%0d_ail_high", i), ha, x.a);
        check($sformatf("f%0d_width_elev", i), we, x.e);
        check($sformatf("f%0d_width_ail", i), wa, x.a);
      end
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b1; pitch = '0; roll = '0; angle_valid = 1'b0; enable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_servo_elev", int'(servo_elev), 0);
    check("rst_servo_ail", int'(servo_ail), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_width_elev", int'(width_elev), C);
    check("rst_width_ail", int'(width_ail), C);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    n = 0;
    while (!frame_start && n < 2 * F) begin
      @(negedge clk);
      n++;
    end
    if (!frame_start) begin
      n_err++;
      $display("FAIL first_frame: no frame_start within %0d cycles", 2 * F);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $fatal(1, "no first frame");
    end

    // The partial frame after reset already hit one update point.
    model_update(1'b1);
    exp_q.push_back('{e: w_e, a: w_a});

    add(1, -1,     0,      0, -1,   0, 0);
    add(1, 400,  160,      0, -1,   0, 0);
    add(1, -1,     0,      0, -1,   0, 0);
    add(1, 100,    0,  30000, -1,   0, 0);
    add(1, 50,     0, -30000, -1,   0, 0);
    add(1, F - 1, -160,    0, -1,   0, 0);
    add(1, -1,     0,      0, -1,   0, 0);
    add(1, 10,   160,    -40, -1,   0, 0);
    for (int i = 0; i < 9; i++) add(1, -1, 0, 0, -1, 0, 0);
    add(0, 20,   160,      0, -1,   0, 0);
    add(1, -1,     0,      0, -1,   0, 0);
    add(1, 30,    -4,      3, -1,   0, 0);
    add(1, 100,   80,      0, 500, -80, 0);
    add(1, -1,     0,      0, -1,   0, 0);

    fork
      measure(steps.size());
      begin
        foreach (steps[i]) run_step(steps[i]);
      end
    join

    repeat (50) @(negedge clk);
    check("pre_rst_elev_high", int'(servo_elev), 1);
    check("pre_rst_ail_high", int'(servo_ail), 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_servo_elev", int'(servo_elev), 0);
    check("mid_rst_servo_ail", int'(servo_ail), 0);
    check("mid_rst_width_elev", int'(width_elev), C);
    check("mid_rst_width_ail", int'(width_ail), C);
    finish_run();
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
